vga_region_gen: RTL and testbench



---
 rtl/vga_region_gen_if.sv | 28 ++
 rtl/vga_region_gen.sv | 163 ++++++++++++++++
 tb/tb_vga_region_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_region_gen_if.sv
// Pixel-colour interface between the region/timing generator and the colour mux.
`default_nettype none

interface vga_region_gen_if;
  logic       pix_en;
  logic [1:0] dim_mode;
  logic       dim_up;
  logic       dim_dn;
  logic       Hsync;
  logic       Vsync;
  logic [2:0] Sel;
  logic [3:0] dimCounter;
  logic       frame_start;
  logic [9:0] hcount;
  logic [9:0] vcount;

  modport master (
    input  pix_en, dim_mode, dim_up, dim_dn,
    output Hsync, Vsync, Sel, dimCounter, frame_start, hcount, vcount
  );

  modport slave (
    output pix_en, dim_mode, dim_up, dim_dn,
    input  Hsync, Vsync, Sel, dimCounter, frame_start, hcount, vcount
  );
endinterface

`default_nettype wire

// File: rtl/vga_region_gen.sv
// VGA timing generator with per-pixel region classification and frame-locked brightness control.
`default_nettype none

module vga_region_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BORDER     = 8,
  parameter int XHAIR_W    = 2,
  parameter int DIM_FRAMES = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  vga_region_gen_if.master  bus
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] BRD      = 10'(BORDER);
  localparam logic [9:0] H_WALL   = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0] V_WALL   = 10'(V_ACTIVE - BORDER);
  localparam logic [9:0] H_MID    = 10'(H_ACTIVE / 2);
  localparam logic [9:0] V_MID    = 10'(V_ACTIVE / 2);
  localparam logic [9:0] XH_LO    = 10'(H_ACTIVE / 2 - XHAIR_W);
  localparam logic [9:0] XH_HI    = 10'(H_ACTIVE / 2 + XHAIR_W - 1);
  localparam logic [9:0] XV_LO    = 10'(V_ACTIVE / 2 - XHAIR_W);
  localparam logic [9:0] XV_HI    = 10'(V_ACTIVE / 2 + XHAIR_W - 1);

  localparam int              DIV_W    = (DIM_FRAMES > 1) ? $clog2(DIM_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIM_FRAMES - 1);
  localparam logic [1:0]      MODE_RAMP   = 2'b01;
  localparam logic [1:0]      MODE_MANUAL = 2'b10;

  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             hsync_q, vsync_q, fs_q;
  logic [2:0]       sel_q;
  logic [3:0]       dim_q, dim_d;
  logic             dir_up_q, dir_up_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       mode_q, mode_d;
  logic             up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;

  logic       w_hsync, w_vsync, w_fs, w_step_up;
  logic [2:0] w_sel;

  // Decode of the current (pre-increment) position.
  always_comb begin
    w_hsync = !((h_q >= HS_START) && (h_q <= HS_END));
    w_vsync = !((v_q >= VS_START) && (v_q <= VS_END));
    w_fs    = (h_q == 10'd0) && (v_q == 10'd0);
    if ((h_q >= H_ACT) || (v_q >= V_ACT))
      w_sel = 3'd0;
    else if ((h_q < BRD) || (h_q >= H_WALL) || (v_q < BRD) || (v_q >= V_WALL))
      w_sel = 3'd6;
    else if (((h_q >= XH_LO) && (h_q <= XH_HI)) || ((v_q >= XV_LO) && (v_q <= XV_HI)))
      w_sel = 3'd1;
    else if (v_q < V_MID)
      w_sel = (h_q < H_MID) ? 3'd2 : 3'd3;
    else
      w_sel = (h_q < H_MID) ? 3'd4 : 3'd5;
  end

  always_comb begin
    h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST)
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
  end

  // Brightness only moves on the edge that starts a frame; manual pulses wait in pending flags.
  always_comb begin
    dim_d     = dim_q;
    dir_up_d  = dir_up_q;
    div_d     = div_q;
    mode_d    = mode_q;
    up_pend_d = up_pend_q | bus.dim_up;
    dn_pend_d = dn_pend_q | bus.dim_dn;
    w_step_up = dir_up_q;
    if (dim_q == 4'd15)
      w_step_up = 1'b0;
    else if (dim_q == 4'd0)
      w_step_up = 1'b1;
    if (bus.pix_en && w_fs) begin
      mode_d    = bus.dim_mode;
      up_pend_d = bus.dim_up;
      dn_pend_d = bus.dim_dn;
      div_d     = '0;
      case (bus.dim_mode)
        MODE_RAMP: begin
          if (bus.dim_mode == mode_q) begin
            if (div_q == DIV_LAST) begin
              dir_up_d = w_step_up;
              dim_d    = w_step_up ? dim_q + 4'd1 : dim_q - 4'd1;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        MODE_MANUAL: begin
          if (up_pend_q && !dn_pend_q && (dim_q != 4'd15))
            dim_d = dim_q + 4'd1;
          else if (dn_pend_q && !up_pend_q && (dim_q != 4'd0))
            dim_d = dim_q - 4'd1;
        end
        default: dim_d = 4'd15;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q       <= '0;
      v_q       <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      sel_q     <= 3'd0;
      fs_q      <= 1'b0;
      dim_q     <= 4'd15;
      dir_up_q  <= 1'b0;
      div_q     <= '0;
      mode_q    <= 2'b00;
      up_pend_q <= 1'b0;
      dn_pend_q <= 1'b0;
    end else begin
      up_pend_q <= up_pend_d;
      dn_pend_q <= dn_pend_d;
      if (bus.pix_en) begin
        h_q      <= h_d;
        v_q      <= v_d;
        hsync_q  <= w_hsync;
        vsync_q  <= w_vsync;
        sel_q    <= w_sel;
        fs_q     <= w_fs;
        dim_q    <= dim_d;
        dir_up_q <= dir_up_d;
        div_q    <= div_d;
        mode_q   <= mode_d;
      end
    end
  end

  assign bus.Hsync       = hsync_q;
  assign bus.Vsync       = vsync_q;
  assign bus.Sel         = sel_q;
  assign bus.frame_start = fs_q;
  assign bus.dimCounter  = dim_q;
  assign bus.hcount      = h_q;
  assign bus.vcount      = v_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_region_gen.sv
// Directed bench: a shrunken-timing instance for frame-level behaviour, a default instance for the first lines.
`default_nettype none

module tb_vga_region_gen;

  localparam int HT = 32;
  localparam int FR = 832;
  localparam int RST_P = 69 * FR + 500;
  localparam int FRZ_P = 69 * FR + 443;

  typedef struct { int h; int v; int sel; } pt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b1;

  vga_region_gen_if ifs ();
  vga_region_gen_if ifd ();

  assign ifs.pix_en   = pix_en;
  assign ifd.pix_en   = pix_en;
  assign ifd.dim_mode = 2'b00;
  assign ifd.dim_up   = 1'b0;
  assign ifd.dim_dn   = 1'b0;

  vga_region_gen #(
    .H_ACTIVE(24), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .BORDER(2), .XHAIR_W(2), .DIM_FRAMES(4)
  ) u_dut_s (.clk(clk), .rst(rst), .bus(ifs));

  vga_region_gen u_dut_d (.clk(clk), .rst(rst), .bus(ifd));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  pt_t s_pts [20] = '{
    '{5,5,2}, '{14,5,3}, '{5,14,4}, '{16,14,5}, '{13,5,1}, '{9,5,2}, '{5,11,1},
    '{5,12,4}, '{1,10,6}, '{2,12,4}, '{21,17,5}, '{22,17,6}, '{23,19,6}, '{5,18,6},
    '{5,1,6}, '{1,9,6}, '{11,1,6}, '{26,5,0}, '{5,22,0}, '{24,0,0}
  };
  pt_t d_pts [13] = '{
    '{100,8,2}, '{400,8,3}, '{319,8,1}, '{321,8,1}, '{322,8,3}, '{317,8,2}, '{4,8,6},
    '{632,8,6}, '{631,8,3}, '{639,8,6}, '{700,8,0}, '{100,7,6}, '{799,8,0}
  };

  initial begin
    int n, p, fpos, frame;
    int hs_low, hs_first, vs_low, vs_first, dvs_low;
    int fs_cnt, fs_bad, dim_mid;
    logic [3:0] prev_dim;
    n = 0; hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1; dvs_low = 0;
    fs_cnt = 0; fs_bad = 0; dim_mid = 0; prev_dim = 4'd15;
    ifs.dim_mode = 2'b01;
    ifs.dim_up   = 1'b0;
    ifs.dim_dn   = 1'b0;

    #12;
    check("rst_hcount", ifs.hcount, 0);
    check("rst_hsync", ifs.Hsync, 1);
    check("rst_vsync", ifs.Vsync, 1);
    check("rst_sel", ifs.Sel, 0);
    check("rst_dim", ifs.dimCounter, 15);
    check("rst_fs", ifs.frame_start, 0);
    @(negedge clk) rst = 1'b0;

    while (1) begin
      @(posedge clk); #1;
      n++;
      p = n - 1;
      fpos = p % FR;
      frame = p / FR;
      ifs.dim_up = 1'b0;
      ifs.dim_dn = 1'b0;

      if (n == 1) begin
        check("first_hcount", ifs.hcount, 1);
        check("first_fs", ifs.frame_start, 1);
        check("first_sel_s", ifs.Sel, 6);
        check("first_sel_d", ifd.Sel, 6);
      end
      if (p < FR) begin
        foreach (s_pts[i])
          if (s_pts[i].v * HT + s_pts[i].h == p)
            check($sformatf("sel_s(%0d,%0d)", s_pts[i].h, s_pts[i].v), ifs.Sel, s_pts[i].sel);
        if (ifs.Vsync == 1'b0) begin
          vs_low++;
          if (vs_first < 0) vs_first = p;
        end
        if (p == FR - 1) begin
          check("vsync_low_ticks", vs_low, 64);
          check("vsync_first_line", vs_first / HT, 22);
        end
      end
      if (p < 8000) begin
        foreach (d_pts[i])
          if (d_pts[i].v * 800 + d_pts[i].h == p)
            check($sformatf("sel_d(%0d,%0d)", d_pts[i].h, d_pts[i].v), ifd.Sel, d_pts[i].sel);
        if (p < 800 && ifd.Hsync == 1'b0) begin
          hs_low++;
          if (hs_first < 0) hs_first = p;
        end
        if (ifd.Vsync == 1'b0) dvs_low++;
        if (p == 799) begin
          check("hsync_low_ticks", hs_low, 96);
          check("hsync_first_h", hs_first, 656);
        end
        if (p == 7999) check("vsync_d_early", dvs_low, 0);
      end

      if (ifs.frame_start) begin
        fs_cnt++;
        if (fpos != 0) fs_bad++;
      end
      if (ifs.dimCounter != prev_dim && fpos != 0) dim_mid++;
      prev_dim = ifs.dimCounter;

      if (fpos == 400) begin
        case (frame)
          0, 3:    check($sformatf("ramp_f%0d", frame), ifs.dimCounter, 15);
          4:       check("ramp_f4", ifs.dimCounter, 14);
          8:       check("ramp_f8", ifs.dimCounter, 13);
          59:      check("ramp_f59", ifs.dimCounter, 1);
          60, 63:  check($sformatf("ramp_f%0d", frame), ifs.dimCounter, 0);
          64:      check("ramp_f64", ifs.dimCounter, 1);
          65:      check("fixed_f65", ifs.dimCounter, 15);
          66:      check("manual_f66", ifs.dimCounter, 15);
          67:      check("manual_up_sat", ifs.dimCounter, 15);
          68:      check("manual_dn", ifs.dimCounter, 14);
          69:      check("manual_both", ifs.dimCounter, 14);
          default: ;
        endcase
        if (frame == 64) ifs.dim_mode = 2'b00;
        if (frame == 65) ifs.dim_mode = 2'b10;
      end
      if (frame == 66 && (fpos == 100 || fpos == 200 || fpos == 300)) ifs.dim_up = 1'b1;
      if (frame == 67 && fpos == 500) ifs.dim_dn = 1'b1;
      if (frame == 68 && fpos == 500) begin
        ifs.dim_up = 1'b1;
        ifs.dim_dn = 1'b1;
      end

      if (p == FRZ_P) begin
        check("pre_freeze_hsync", ifs.Hsync, 0);
        pix_en = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        check("frz_hcount", ifs.hcount, 28);
        check("frz_vcount", ifs.vcount, 13);
        check("frz_sel", ifs.Sel, 0);
        check("frz_hsync", ifs.Hsync, 0);
        pix_en = 1'b1;
      end

      if (p == RST_P) begin
        check("sel_s(20,15)", ifs.Sel, 5);
        check("hcount_pre_rst", ifs.hcount, 21);
        check("fs_count", fs_cnt, 70);
        check("fs_misplaced", fs_bad, 0);
        check("dim_midframe", dim_mid, 0);
        break;
      end
    end

    #2 rst = 1'b1;
    #1;
    check("arst_hcount", ifs.hcount, 0);
    check("arst_vcount", ifs.vcount, 0);
    check("arst_hsync", ifs.Hsync, 1);
    check("arst_vsync", ifs.Vsync, 1);
    check("arst_sel", ifs.Sel, 0);
    check("arst_dim", ifs.dimCounter, 15);
    check("arst_hcount_d", ifd.hcount, 0);
    pix_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_sel", ifs.Sel, 0);
    check("idle_hsync", ifs.Hsync, 1);
    check("idle_hcount", ifs.hcount, 0);
    pix_en = 1'b1;
    @(posedge clk); #1;
    check("post_hcount", ifs.hcount, 1);
    check("post_fs", ifs.frame_start, 1);
    check("post_sel", ifs.Sel, 6);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
